nibble_serial_adder_ctrl: RTL
=============================

Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one instance of the team's combinational 4-bit ripple slice (four_bit_FA), one nibble per clock, LSB nibble first.
- Registers operands, carry and partial result, and exposes a start/busy/done handshake to the requesting logic.
- Sits between a control unit and the adder slice. Trades latency for area on wide datapaths.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4 (derived, not overridable), number of nibble steps per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured when start is accepted
- b  input  WIDTH  operand B, captured when start is accepted
- cin  input  1  carry-in for add; ignored when sub=1
- sub  input  1  0: sum=a+b+cin; 1: sum=a-b (a+~b+1); captured with operands
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  registered result
- cout  output  1  final carry-out; for sub, 1 means no borrow
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; all internal registers cleared. An operation in flight is abandoned and produces no done.
- FSM states:
  - IDLE: if start=1 at an edge, capture opa=a, opb = sub ? ~b : b, carry = sub ? 1 : cin, count=0, and remember the MSBs of a and of the (possibly inverted) opb; go to RUN. Otherwise stay in IDLE.
  - RUN: each edge, the slice adds opa[3:0], opb[3:0] and carry. The slice sum shifts into the top nibble of the result shift register (shift right by 4). opa and opb shift right by 4. carry takes the slice carry-out; count increments. When count=NIB-1 at the edge, go to DONE and load sum, cout and ovf from the completed result.
  - DONE: done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- start is ignored in RUN and DONE; no queueing. Operands may change freely after acceptance.
- Latency: start accepted at edge E -> sum/cout/ovf update at edge E+NIB, done high for the cycle following that edge. For WIDTH=16: E+4.
- Throughput: with start held high, one operation is accepted every NIB+2 cycles (6 for WIDTH=16).
- sum, cout and ovf hold their last values until the next completion. They are not disturbed while a new operation runs.
- ovf = (MSB of a == MSB of opb) AND (MSB of sum != MSB of a), using the inverted b for subtraction.
- Width rules: all arithmetic is modulo 2^WIDTH. The carry out of the final nibble is cout.
- busy = (state != IDLE). done and busy are registered outputs with no combinational path from start.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0FCD, cin=0, sub=0, pulse start -> done 4 cycles after acceptance; sum=0x2201, cout=0, ovf=0; busy high for 5 cycles.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0; checks carry ripple across all nibble steps. Repeat with cin=1, b=0x0000 -> same result.
- a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0. Pulse start with different operands during RUN -> ignored; result unchanged, single done pulse.
- Hold start=1 continuously with a=0x0001, b=0x0001 -> done pulses every 6 cycles, sum=0x0002 each time. Assert rst for 1 cycle mid-RUN (count=2) -> outputs immediately 0, no done pulse; next start completes normally.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequencer that reuses one 4-bit ripple slice,
// one nibble per clock, LSB nibble first, behind a start/busy/done handshake.

module four_bit_FA (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c   = {4'b0000, cin};
    sum = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, nstate;
  logic [WIDTH-1:0] opa, opb, res;
  logic             carry;
  logic [CW-1:0]    count;
  logic             amsb, bmsb;
  logic [3:0]       s_sum;
  logic             s_cout;
  logic             last;

  four_bit_FA u_slice (
    .a    (opa[3:0]),
    .b    (opb[3:0]),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout)
  );

  assign last = (count == CW'(NIB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = RUN;
      RUN:     if (last)  nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // busy/done are flopped from the next-state decode so start never reaches them combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (nstate != IDLE);
      done <= (nstate == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      count <= '0;
      amsb  <= 1'b0;
      bmsb  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            count <= '0;
            amsb  <= a[WIDTH-1];
            bmsb  <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
          end
        end
        RUN: begin
          res   <= {s_sum, res[WIDTH-1:4]};
          opa   <= opa >> 4;
          opb   <= opb >> 4;
          carry <= s_cout;
          count <= count + CW'(1);
          // final nibble: its slice output is the result MSB nibble
          if (last) begin
            sum  <= {s_sum, res[WIDTH-1:4]};
            cout <= s_cout;
            ovf  <= (amsb == bmsb) && (s_sum[3] != amsb);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
